// File: rtl/pes_half_adder.sv
// rtl/pes_half_adder.sv - 1-bit half adder with registered copy and saturating carry counter
//
// The combinational sum/carry are the arithmetic reference. They are driven
// straight from i_a/i_b, so they ignore clock, enable and reset. Registered
// copies and a carry-event counter are provided for timing closure and statistics.
//
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset; clears the registered outputs and the counter
//   i_a, i_b     addends
//   i_en         capture the registered outputs and allow the counter to increment
//   i_cnt_clr    synchronous counter clear; takes priority over increment
//   o_sum        combinational i_a ^ i_b
//   o_carry      combinational i_a & i_b
//   o_sum_q      registered sum, loaded when i_en=1
//   o_carry_q    registered carry, loaded when i_en=1
//   o_carry_cnt  saturating count of enabled cycles with carry=1

module pes_half_adder #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_a,
  input  logic             i_b,
  input  logic             i_en,
  input  logic             i_cnt_clr,
  output logic             o_sum,
  output logic             o_carry,
  output logic             o_sum_q,
  output logic             o_carry_q,
  output logic [CNT_W-1:0] o_carry_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sum_c;
  logic             carry_c;
  logic             sum_d,   sum_q;
  logic             carry_d, carry_q;
  logic [CNT_W-1:0] cnt_d,   cnt_q;

  // {carry,sum} is the 2-bit result of a 1-bit add.
  assign sum_c   = i_a ^ i_b;
  assign carry_c = i_a & i_b;

  assign o_sum   = sum_c;
  assign o_carry = carry_c;

  always_comb begin
    sum_d   = sum_q;
    carry_d = carry_q;
    if (i_en) begin
      sum_d   = sum_c;
      carry_d = carry_c;
    end
  end

  // A clear wins over an increment. The counter holds at all ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (i_cnt_clr) begin
      cnt_d = '0;
    end else if (i_en && carry_c && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_sum_q     = sum_q;
  assign o_carry_q   = carry_q;
  assign o_carry_cnt = cnt_q;

endmodule

// File: tb/tb_pes_half_adder.sv
// tb/tb_pes_half_adder.sv - directed self-checking bench for pes_half_adder

module tb_pes_half_adder;

  logic       clk;
  logic       rst_n;
  logic       a, b, en, clr;
  logic       sum8, carry8, sum_q8, carry_q8;
  logic [7:0] cnt8;
  logic       sum2, carry2, sum_q2, carry_q2;
  logic [1:0] cnt2;

  int n_cmp = 0;
  int n_mis = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pes_half_adder #(.CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_en(en), .i_cnt_clr(clr),
    .o_sum(sum8), .o_carry(carry8), .o_sum_q(sum_q8), .o_carry_q(carry_q8),
    .o_carry_cnt(cnt8)
  );

  pes_half_adder #(.CNT_W(2)) u_dut_sat (
    .i_clk(clk), .i_rst_n(rst_n), .i_a(a), .i_b(b), .i_en(en), .i_cnt_clr(clr),
    .o_sum(sum2), .o_carry(carry2), .o_sum_q(sum_q2), .o_carry_q(carry_q2),
    .o_carry_cnt(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] comb_in  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  logic [1:0] comb_exp [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
  int         sat_exp  [5] = '{1, 2, 3, 3, 3};

  initial begin
    rst_n = 1'b0; a = 1'b0; b = 1'b0; en = 1'b0; clr = 1'b0;
    #2;
    check("rst_sum_q",   32'(sum_q8),   0);
    check("rst_carry_q", 32'(carry_q8), 0);
    check("rst_cnt",     32'(cnt8),     0);

    // Exhaustive combinational check. Reset is still asserted, so no clock edge is involved.
    for (int i = 0; i < 4; i++) begin
      {a, b} = comb_in[i];
      #2;
      check("comb_carry", 32'(carry8), 32'(comb_exp[i][1]));
      check("comb_sum",   32'(sum8),   32'(comb_exp[i][0]));
      #3;
    end

    @(negedge clk);
    rst_n = 1'b1; a = 1'b0; b = 1'b0;

    // Random vectors with en=0. The registered outputs must stay at their reset values.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      #1;
      check("rand_add", 32'({carry8, sum8}), 32'(a) + 32'(b));
    end
    check("rand_hold_cnt", 32'(cnt8), 0);

    // Enable and latency.
    @(negedge clk); a = 1; b = 1; en = 1;
    edge_sample();
    check("en_carry_q", 32'(carry_q8), 1);
    check("en_sum_q",   32'(sum_q8),   0);
    check("en_cnt",     32'(cnt8),     1);
    @(negedge clk); en = 0; a = 1; b = 0;
    edge_sample();
    check("hold_carry_q", 32'(carry_q8), 1);
    check("hold_sum_q",   32'(sum_q8),   0);
    check("hold_cnt",     32'(cnt8),     1);
    check("hold_comb_sum", 32'(sum8),    1);

    // Clear priority. Reach cnt=2, then clear while an increment is also requested.
    @(negedge clk); a = 1; b = 1; en = 1;
    edge_sample();
    check("pre_clr_cnt", 32'(cnt8), 2);
    @(negedge clk); clr = 1;
    edge_sample();
    check("clr_cnt",     32'(cnt8), 0);
    check("clr_cnt_sat", 32'(cnt2), 0);
    @(negedge clk); clr = 0;
    edge_sample();
    check("post_clr_cnt", 32'(cnt8), 1);

    // Saturation on the 2-bit counter.
    @(negedge clk); clr = 1;
    edge_sample();
    @(negedge clk); clr = 0;
    for (int i = 0; i < 5; i++) begin
      edge_sample();
      check("sat_cnt2", 32'(cnt2), 32'(sat_exp[i]));
      check("sat_cnt8", 32'(cnt8), 32'(i + 1));
    end

    // Async reset with cnt=5 and sum_q=1.
    @(negedge clk); a = 1; b = 0; en = 1;
    edge_sample();
    check("pre_rst_sum_q", 32'(sum_q8), 1);
    check("pre_rst_cnt",   32'(cnt8),   5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sum_q",   32'(sum_q8),   0);
    check("arst_carry_q", 32'(carry_q8), 0);
    check("arst_cnt",     32'(cnt8),     0);
    check("arst_comb_sum", 32'(sum8),    1);
    a = 1; b = 1;
    edge_sample();
    check("arst_hold_cnt",     32'(cnt8),     0);
    check("arst_hold_carry_q", 32'(carry_q8), 0);

    @(negedge clk); rst_n = 1'b1;
    edge_sample();
    check("restart_cnt",     32'(cnt8),     1);
    check("restart_carry_q", 32'(carry_q8), 1);
    check("restart_sum_q",   32'(sum_q8),   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
